// File: rtl/fft_sdf_stage.sv
// fft_sdf_stage: radix-2 DIF single-path delay-feedback FFT stage; define FFT_SDF_SCALE_EN to halve every output
module fft_sdf_stage #(
  parameter int IN_W = 13,
  parameter int LOG2_N = 3,
  parameter int STAGE = 0,
  parameter int TW_W = 10,
`ifdef FFT_SDF_SCALE_EN
  localparam int OUT_W = IN_W
`else
  localparam int OUT_W = IN_W + 1
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_real,
  input  logic signed [IN_W-1:0]  in_imag,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_real,
  output logic signed [OUT_W-1:0] out_imag
);
  localparam int D = 2 ** (LOG2_N - 1 - STAGE);
  localparam int CW = LOG2_N - STAGE;
  localparam int IW = CW > 1 ? CW - 1 : 1;
  localparam int DW = IN_W + 1;
  localparam int AW = IN_W + TW_W + 2;
  localparam logic signed [AW-1:0] MAXV = AW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  function automatic logic signed [TW_W-1:0] tw(input int k, input bit s);
    real a = 3.141592653589793 * k / D;
    real v = (2.0 ** (TW_W - 2)) * (s ? $sin(a) : $cos(a));
    return TW_W'($rtoi(v < 0.0 ? v - 0.5 : v + 0.5));
  endfunction
  function automatic logic signed [OUT_W-1:0] sat(input logic signed [AW-1:0] v);
    return v > MAXV ? OUT_W'(MAXV) : v < MINV ? OUT_W'(MINV) : OUT_W'(v);
  endfunction
  logic signed [TW_W-1:0] rom_c [2**IW];
  logic signed [TW_W-1:0] rom_s [2**IW];
  for (genvar i = 0; i < 2 ** IW; i++) begin : g_rom
    assign rom_c[i] = tw(i, 1'b0);
    assign rom_s[i] = tw(i, 1'b1);
  end
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic primed, phase_b;
  logic signed [DW-1:0] dl_r [D];
  logic signed [DW-1:0] dl_i [D];
  logic signed [DW-1:0] hr, hi, xr, xi, dr, di;
  logic signed [AW-1:0] qr, qi, sr, si, yr, yi;
  logic signed [OUT_W-1:0] nr, ni;
  // butterfly in phase B, twiddle rotation of the stored difference in phase A
  always_comb begin
    phase_b = cnt[CW-1];
    idx = IW'(cnt);
    hr = dl_r[D-1];
    hi = dl_i[D-1];
    xr = DW'(in_real);
    xi = DW'(in_imag);
    qr = (AW'(hr) * AW'(rom_c[idx]) + AW'(hi) * AW'(rom_s[idx]) + AW'(2 ** (TW_W - 3))) >>> (TW_W - 2);
    qi = (AW'(hi) * AW'(rom_c[idx]) - AW'(hr) * AW'(rom_s[idx]) + AW'(2 ** (TW_W - 3))) >>> (TW_W - 2);
    sr = phase_b ? AW'(hr) + AW'(xr) : (idx == '0 ? AW'(hr) : qr);
    si = phase_b ? AW'(hi) + AW'(xi) : (idx == '0 ? AW'(hi) : qi);
`ifdef FFT_SDF_SCALE_EN
    yr = (sr + AW'(1)) >>> 1;
    yi = (si + AW'(1)) >>> 1;
`else
    yr = sr;
    yi = si;
`endif
    nr = sat(yr);
    ni = sat(yi);
    dr = phase_b ? hr - xr : xr;
    di = phase_b ? hi - xi : xi;
  end
  // counter, delay line, priming and registered outputs advance only on accepted samples
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      primed <= 1'b0;
      out_valid <= 1'b0;
      out_real <= '0;
      out_imag <= '0;
      for (int k = 0; k < D; k++) begin
        dl_r[k] <= '0;
        dl_i[k] <= '0;
      end
    end else begin
      out_valid <= in_valid & (primed | phase_b);
      if (in_valid) begin
        cnt <= cnt + 1'b1;
        primed <= primed | phase_b;
        out_real <= nr;
        out_imag <= ni;
        dl_r[0] <= dr;
        dl_i[0] <= di;
        for (int k = 1; k < D; k++) begin
          dl_r[k] <= dl_r[k-1];
          dl_i[k] <= dl_i[k-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_sdf_stage.sv
// tb_fft_sdf_stage: randomized and directed check of fft_sdf_stage against an input-history model
module tb_fft_sdf_stage;
  localparam int IN_W = 13;
  localparam int LOG2_N = 3;
  localparam int STAGE = 0;
  localparam int TW_W = 10;
`ifdef FFT_SDF_SCALE_EN
  localparam int OUT_W = IN_W;
  localparam int IMP = 50;
`else
  localparam int OUT_W = IN_W + 1;
  localparam int IMP = 100;
`endif
  localparam int D = 2 ** (LOG2_N - 1 - STAGE);
  localparam int ONE = 2 ** (TW_W - 2);
  localparam int OMAX = 2 ** (OUT_W - 1) - 1;
  localparam real PI = 3.141592653589793;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [IN_W-1:0] in_real = '0;
  logic signed [IN_W-1:0] in_imag = '0;
  logic out_valid;
  logic signed [OUT_W-1:0] out_real, out_imag;

  fft_sdf_stage #(.IN_W(IN_W), .LOG2_N(LOG2_N), .STAGE(STAGE), .TW_W(TW_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_real(out_real), .out_imag(out_imag)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0;
  bit chk_en = 1'b0;
  int hist_r[$], hist_i[$];
  int mcnt = 0;
  bit mprimed = 1'b0;
  bit nxt_v = 1'b0, exp_v = 1'b0;
  int nxt_r = 0, nxt_i = 0, exp_r = 0, exp_i = 0;
  int got_r[$], got_i[$], ref_r[$], ref_i[$];
  int ar[16], ai[16];

  function automatic int post(longint v);
`ifdef FFT_SDF_SCALE_EN
    v = (v + 1) >>> 1;
`endif
    return v > OMAX ? OMAX : v < -OMAX - 1 ? -OMAX - 1 : int'(v);
  endfunction

  function automatic int fix(longint v);
    return int'((v + ONE / 2) >>> (TW_W - 2));
  endfunction

  // output of sample n: phase B sums x[n-D]+x[n]; phase A rotates x[n-2D]-x[n-D] by W_2D^cnt
  task automatic model(input bit rs, input bit v, input int r, input int i);
    int n, c, s, dr, di;
    if (rs) begin
      hist_r.delete();
      hist_i.delete();
      repeat (2 * D) begin
        hist_r.push_back(0);
        hist_i.push_back(0);
      end
      mcnt = 0;
      mprimed = 1'b0;
      nxt_v = 1'b0;
      nxt_r = 0;
      nxt_i = 0;
    end else if (!v) begin
      nxt_v = 1'b0;
    end else begin
      hist_r.push_back(r);
      hist_i.push_back(i);
      n = hist_r.size() - 1;
      if (mcnt >= D) begin
        nxt_r = post(longint'(hist_r[n-D]) + r);
        nxt_i = post(longint'(hist_i[n-D]) + i);
        mprimed = 1'b1;
        nxt_v = 1'b1;
      end else begin
        dr = hist_r[n-2*D] - hist_r[n-D];
        di = hist_i[n-2*D] - hist_i[n-D];
        c = int'(ONE * $cos(PI * mcnt / D));
        s = int'(ONE * $sin(PI * mcnt / D));
        nxt_r = post(mcnt == 0 ? longint'(dr) : longint'(fix(longint'(dr) * c + longint'(di) * s)));
        nxt_i = post(mcnt == 0 ? longint'(di) : longint'(fix(longint'(di) * c - longint'(dr) * s)));
        nxt_v = mprimed;
      end
      mcnt = (mcnt + 1) % (2 * D);
    end
  endtask

  task automatic cyc(input bit rs, input bit v, input int r, input int i);
    rst = rs;
    in_valid = v;
    in_real = IN_W'(r);
    in_imag = IN_W'(i);
    model(rs, v, r, i);
    @(posedge clk);
    #1;
    exp_v = nxt_v;
    exp_r = nxt_r;
    exp_i = nxt_i;
    if (out_valid === 1'b1) begin
      got_r.push_back(int'(out_real));
      got_i.push_back(int'(out_imag));
    end
  endtask

  task automatic pin(input string nm, input int act, input int expv);
    ncmp++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic run_block(input int gap_at);
    cyc(1'b1, 1'b0, 0, 0);
    got_r.delete();
    got_i.delete();
    for (int n = 0; n < 16; n++) begin
      if (n == gap_at) repeat (3) cyc(1'b0, 1'b0, 0, 0);
      cyc(1'b0, 1'b1, ar[n], ai[n]);
    end
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 2 ** IN_W - 1)) - 2 ** (IN_W - 1);
  endfunction

  // every cycle: outputs against the model's expectation for the edge just passed
  always @(negedge clk) begin
    if (chk_en) begin
      ncmp++;
      if (out_valid !== exp_v) begin
        nfail++;
        $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, exp_v);
      end
      ncmp++;
      if (int'(out_real) !== exp_r || int'(out_imag) !== exp_i) begin
        nfail++;
        $display("FAIL out_data @%0t: got (%0d,%0d) expected (%0d,%0d)", $time, out_real, out_imag, exp_r, exp_i);
      end
    end
  end

  initial begin
    cyc(1'b1, 1'b1, 77, 33);
    cyc(1'b1, 1'b0, 0, 0);
    chk_en = 1'b1;
    pin("reset out_valid", int'(out_valid), 0);
    pin("reset out_real", int'(out_real), 0);
    pin("reset out_imag", int'(out_imag), 0);

    for (int n = 0; n < 16; n++) begin ar[n] = 0; ai[n] = 0; end
    ar[0] = 100;
    run_block(-1);
    pin("impulse count", got_r.size(), 12);
    for (int k = 0; k < 8; k++) begin
      pin("impulse real", got_r[k], (k % 4 == 0) ? IMP : 0);
      pin("impulse imag", got_i[k], 0);
    end

`ifndef FFT_SDF_SCALE_EN
    for (int n = 0; n < 16; n++) begin ar[n] = 1000; ai[n] = 0; end
    run_block(-1);
    pin("dc phase B", got_r[0], 2000);
    pin("dc phase A", got_r[4], 0);

    for (int n = 0; n < 16; n++) begin ar[n] = 0; ai[n] = 0; end
    ar[1] = 100;
    run_block(-1);
    pin("twiddle k1 real", got_r[5], 71);
    pin("twiddle k1 imag", got_i[5], -71);

    ar[1] = 4095; ai[1] = 4095; ar[5] = -4096; ai[5] = -4096;
    run_block(-1);
    pin("saturate real", got_r[5], 8191);
    pin("saturate imag", got_i[5], 0);
`endif

    for (int n = 0; n < 16; n++) begin ar[n] = rnd(); ai[n] = rnd(); end
    run_block(-1);
    ref_r = got_r;
    ref_i = got_i;
    run_block(10);
    pin("gap count", got_r.size(), ref_r.size());
    for (int k = 0; k < ref_r.size(); k++) begin
      pin("gap real", got_r[k], ref_r[k]);
      pin("gap imag", got_i[k], ref_i[k]);
    end

    cyc(1'b1, 1'b0, 0, 0);
    for (int n = 0; n < 16; n++) cyc(1'b0, 1'b1, rnd(), rnd());
    for (int n = 0; n < 5; n++) cyc(1'b0, 1'b1, rnd(), rnd());
    cyc(1'b1, 1'b1, rnd(), rnd());
    pin("midrst out_valid", int'(out_valid), 0);
    pin("midrst out_real", int'(out_real), 0);
    pin("midrst out_imag", int'(out_imag), 0);
    for (int n = 0; n < 4; n++) begin
      cyc(1'b0, 1'b1, rnd(), rnd());
      pin("midrst no valid", int'(out_valid), 0);
    end
    cyc(1'b0, 1'b1, rnd(), rnd());
    pin("midrst first valid", int'(out_valid), 1);

    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 0) cyc(1'b0, 1'b1, (n % 100 == 0) ? 4095 : -4096, (n % 100 == 0) ? -4096 : 4095);
      else cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rnd(), rnd());
    end
    cyc(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
